// File: rtl/safe_pkg.sv
// ============================================================================
// Module : safe_pkg
// Brief  : Shared types and default constants for the digital-safe datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package safe_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } lk_state_t;

  localparam int c_MAX_FAILS_DFLT      = 3;
  localparam int c_OPEN_CYCLES_DFLT    = 250000000;
  localparam int c_LOCKOUT_CYCLES_DFLT = 1500000000;
  localparam int c_ALARM_LOCKOUTS_DFLT = 2;

  // Code length used by the upstream serial code-checker.
  localparam int c_N = 4;

  function automatic int safe_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/safe_down_timer.sv
// ============================================================================
// Module : safe_down_timer
// Brief  : Loadable down-counter that stops at zero; expired flags zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module safe_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/safe_lockout_ctrl.sv
// ============================================================================
// Module : safe_lockout_ctrl
// Brief  : Latch drive, consecutive-failure counting and timed lockout for the
//          safe. Optional escalation alarm built when SAFE_ALARM_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module safe_lockout_ctrl
  import safe_pkg::*;
#(
  parameter int MAX_FAILS      = c_MAX_FAILS_DFLT,
  parameter int OPEN_CYCLES    = c_OPEN_CYCLES_DFLT,
  parameter int LOCKOUT_CYCLES = c_LOCKOUT_CYCLES_DFLT,
  parameter int ALARM_LOCKOUTS = c_ALARM_LOCKOUTS_DFLT
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           unlock_valid,
  input  logic                           unlock,
  input  logic                           incorrect,
  input  logic                           relock_req,
  output logic                           latch_open,
  output logic                           accept_en,
  output logic                           locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
  output logic                           alarm
);

  localparam int c_FW = $clog2(MAX_FAILS + 1);
  localparam int c_TW = $clog2(safe_max(safe_max(OPEN_CYCLES, LOCKOUT_CYCLES), 2));

  if (MAX_FAILS < 1 || ALARM_LOCKOUTS < 1 || OPEN_CYCLES < 1 || LOCKOUT_CYCLES < 1)
  begin : g_param_check
    $error("safe_lockout_ctrl: all count parameters must be >= 1");
  end

  lk_state_t        r_state;
  lk_state_t        w_state_nxt;
  logic             r_ok_prev;
  logic             r_fail_prev;
  logic             w_ok_lvl;
  logic             w_ok_ev;
  logic             w_fail_ev;
  logic [c_FW-1:0]  r_fail_count;
  logic [c_FW-1:0]  w_fail_nxt;
  logic             w_tmr_load;
  logic [c_TW-1:0]  w_tmr_val;
  logic             w_tmr_expired;

  assign w_ok_lvl  = unlock_valid & unlock;
  assign w_ok_ev   = w_ok_lvl & ~r_ok_prev;
  assign w_fail_ev = incorrect & ~r_fail_prev;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= LOCKED;
      r_fail_count <= '0;
      r_ok_prev    <= 1'b0;
      r_fail_prev  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fail_count <= w_fail_nxt;
      r_ok_prev    <= w_ok_lvl;
      r_fail_prev  <= incorrect;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = r_fail_count;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    case (r_state)
      LOCKED: begin
        // A simultaneous fail is dropped: a good code always wins.
        if (w_ok_ev) begin
          w_state_nxt = OPEN;
          w_fail_nxt  = '0;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_TW'(OPEN_CYCLES - 1);
        end else if (w_fail_ev) begin
          w_fail_nxt = r_fail_count + 1'b1;
          if (w_fail_nxt == c_FW'(MAX_FAILS)) begin
            w_state_nxt = LOCKOUT;
            w_tmr_load  = 1'b1;
            w_tmr_val   = c_TW'(LOCKOUT_CYCLES - 1);
          end
        end
      end
      OPEN: begin
        if (relock_req) begin
          w_state_nxt = LOCKED;
          w_tmr_load  = 1'b1;
        end else if (w_tmr_expired) begin
          w_state_nxt = LOCKED;
        end
      end
      LOCKOUT: begin
        if (w_tmr_expired) begin
          w_state_nxt = LOCKED;
          w_fail_nxt  = '0;
        end
      end
      default: w_state_nxt = LOCKED;
    endcase
  end

  always_comb begin
    latch_open = 1'b0;
    accept_en  = 1'b0;
    locked_out = 1'b0;
    case (r_state)
      LOCKED:  accept_en  = 1'b1;
      OPEN:    latch_open = 1'b1;
      LOCKOUT: locked_out = 1'b1;
      default: accept_en  = 1'b0;
    endcase
  end

  assign fail_count = r_fail_count;

  safe_down_timer #(
    .WIDTH(c_TW)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .expired  (w_tmr_expired)
  );

`ifdef SAFE_ALARM_EN
  localparam int c_AW = $clog2(ALARM_LOCKOUTS + 1);

  logic [c_AW-1:0] r_lo_cnt;
  logic            r_alarm;
  logic            w_lockout_entry;

  assign w_lockout_entry = (r_state == LOCKED) && (w_state_nxt == LOCKOUT);

  // Expiry of a lockout deliberately leaves the escalation history intact.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lo_cnt <= '0;
      r_alarm  <= 1'b0;
    end else if ((r_state == LOCKED) && w_ok_ev) begin
      r_lo_cnt <= '0;
      r_alarm  <= 1'b0;
    end else if (w_lockout_entry && (r_lo_cnt != c_AW'(ALARM_LOCKOUTS))) begin
      r_lo_cnt <= r_lo_cnt + 1'b1;
      r_alarm  <= ((r_lo_cnt + 1'b1) == c_AW'(ALARM_LOCKOUTS));
    end
  end

  assign alarm = r_alarm;
`else
  assign alarm = 1'b0;
`endif

endmodule

`default_nettype wire
